// File: rtl/regs_op_sequencer.sv
// ============================================================================
// Module   : regs_op_sequencer
// Purpose  : Single-issue micro-op sequencer for a 2R/1W register file.
//            Accepts one 3-operand op per handshake, reads both operands,
//            runs a small ALU op and writes the result back.
// Options  : REGSEQ_FAST_EN - drop the EXEC state; the ALU result is taken
//            combinationally from the read data in READ (3-cycle ops).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module regs_op_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_op,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  input  logic [ADDR_WIDTH-1:0] i_rs2,
  input  logic [DATA_WIDTH-1:0] i_imm,
  output logic [ADDR_WIDTH-1:0] o_reg0,
  output logic [ADDR_WIDTH-1:0] o_reg1,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic [ADDR_WIDTH-1:0] o_reg2,
  output logic [DATA_WIDTH-1:0] o_data2,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_zero
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
`ifndef REGSEQ_FAST_EN
  localparam logic [1:0] ST_EXEC = 2'd2;
`endif
  localparam logic [1:0] ST_WB   = 2'd3;

  // Opcodes
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_MOV = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  logic [1:0]            state_q, state_d;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic [DATA_WIDTH-1:0] alu_d;
  logic                  accept;
  logic                  result_en;

  // ALU: add/sub wrap modulo 2^DATA_WIDTH, carry/borrow dropped
  function automatic logic [DATA_WIDTH-1:0] alu_f(
    input logic [2:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] imm
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MOV:  r = a;
      OP_LDI:  r = imm;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept = (state_q == ST_IDLE) && i_valid;

`ifdef REGSEQ_FAST_EN
  // Fast path: result comes straight from the register-file read data
  assign alu_d     = alu_f(op_q, i_data0, i_data1, imm_q);
  assign result_en = (state_q == ST_READ) && (op_q != OP_NOP);
`else
  logic [DATA_WIDTH-1:0] op1_q, op2_q;

  assign alu_d     = alu_f(op_q, op1_q, op2_q, imm_q);
  assign result_en = (state_q == ST_EXEC) && (op_q != OP_NOP);

  // Capture both operands at the end of READ
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      op1_q <= '0;
      op2_q <= '0;
    end else if (state_q == ST_READ) begin
      op1_q <= i_data0;
      op2_q <= i_data1;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_valid) state_d = ST_READ;
`ifdef REGSEQ_FAST_EN
      ST_READ: state_d = ST_WB;
`else
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
`endif
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; async reset lands in IDLE so a pending write is dropped
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Latch the command fields on acceptance; later input changes are ignored
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      op_q  <= OP_NOP;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= i_op;
      rd_q  <= i_rd;
      rs1_q <= i_rs1;
      rs2_q <= i_rs2;
      imm_q <= i_imm;
    end
  end

  // Result and zero flag; a NOP leaves both untouched
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (result_en) begin
      result_q <= alu_d;
      zero_q   <= (alu_d == '0);
    end
  end

  // Register-file ports are only driven in the state that owns them
  assign o_ready  = (state_q == ST_IDLE);
  assign o_reg0   = (state_q == ST_READ) ? rs1_q : '0;
  assign o_reg1   = (state_q == ST_READ) ? rs2_q : '0;
  assign o_reg2   = ((state_q == ST_WB) && (op_q != OP_NOP)) ? rd_q : '0;
  assign o_data2  = (state_q == ST_WB) ? result_q : '0;
  assign o_done   = (state_q == ST_WB);
  assign o_result = result_q;
  assign o_zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_regs_op_sequencer.sv
// ============================================================================
// Module   : tb_regs_op_sequencer
// Purpose  : Self-checking bench for regs_op_sequencer with a behavioural
//            register file and an expected-write scoreboard.
// Options  : REGSEQ_FAST_EN - selects 3-cycle op timing expectations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regs_op_sequencer;

`ifdef REGSEQ_FAST_EN
  localparam int LAT = 1;   // edges from accept to entering WB
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] op = 3'd0;
  logic [4:0] rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [7:0] imm = 8'd0;

  logic       o_ready, o_done, o_zero;
  logic [4:0] o_reg0, o_reg1, o_reg2;
  logic [7:0] o_data2, o_result, data0, data1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  regs_op_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_op(op), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
    .o_reg0(o_reg0), .o_reg1(o_reg1), .i_data0(data0), .i_data1(data1),
    .o_reg2(o_reg2), .o_data2(o_data2), .o_done(o_done),
    .o_result(o_result), .o_zero(o_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file: r0 reads zero, writes to r0 dropped
  logic [7:0] rf [32];
  logic       rf_clr = 1'b1;
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 8'h00;
    end else if (o_reg2 != 5'd0) begin
      rf[o_reg2] <= o_data2;
    end
  end
  assign data0 = (o_reg0 == 5'd0) ? 8'h00 : rf[o_reg0];
  assign data1 = (o_reg1 == 5'd0) ? 8'h00 : rf[o_reg1];

  // Scoreboard entries and reference model state
  typedef struct {
    logic [4:0] wa;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [7:0] wd;
    logic [7:0] res;
    logic       z;
  } exp_t;
  exp_t       q[$];
  logic [7:0] mrf [32];
  logic [7:0] last_res = 8'h00;
  logic       last_z = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] o, input logic [4:0] d, s1, s2, input logic [7:0] im);
    exp_t e;
    logic [7:0] a, b, f;
    a = mrf[s1];
    b = mrf[s2];
    case (o)
      3'd1: f = a + b;
      3'd2: f = a - b;
      3'd3: f = a & b;
      3'd4: f = a | b;
      3'd5: f = a ^ b;
      3'd6: f = a;
      3'd7: f = im;
      default: f = 8'h00;
    endcase
    if (o != 3'd0) begin
      last_res = f;
      last_z   = (f == 8'h00);
      if (d != 5'd0) mrf[d] = f;
    end
    e.wa  = (o == 3'd0) ? 5'd0 : d;
    e.rs1 = s1;
    e.rs2 = s2;
    e.wd  = last_res;
    e.res = last_res;
    e.z   = last_z;
    q.push_back(e);
  endtask

  // Wait for IDLE (entered at a negedge), present a command, return accept cycle
  task automatic send(input logic [2:0] o, input logic [4:0] d, s1, s2,
                      input logic [7:0] im, input bit keep, output int t);
    int n = 0;
    while (o_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", {31'd0, o_ready}, 32'd1);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; valid = 1'b1;
    push_exp(o, d, s1, s2, im);
    @(posedge clk);
    #1;
    t = cyc;
    if (!keep) valid = 1'b0;
  endtask

  // Observe the op through WB and compare against the scoreboard head
  task automatic finish_op(input int t);
    exp_t e;
    bit   seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        seen = 1'b1;
        chk("sb_nonempty", q.size(), (q.size() == 0) ? 32'd1 : q.size());
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("wb_latency", cyc - t, LAT);
          chk("wb_addr",   {27'd0, o_reg2},  {27'd0, e.wa});
          chk("wb_data",   {24'd0, o_data2}, {24'd0, e.wd});
          chk("wb_result", {24'd0, o_result}, {24'd0, e.res});
          chk("wb_zero",   {31'd0, o_zero},  {31'd0, e.z});
        end
      end else begin
        chk("busy_reg2",  {27'd0, o_reg2},  32'd0);
        chk("busy_ready", {31'd0, o_ready}, 32'd0);
        if (cyc == t && q.size() != 0) begin
          chk("read_reg0", {27'd0, o_reg0}, {27'd0, q[0].rs1});
          chk("read_reg1", {27'd0, o_reg1}, {27'd0, q[0].rs2});
        end else begin
          chk("idle_reg0", {27'd0, o_reg0}, 32'd0);
        end
      end
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL done_timeout: observed=no_done expected=done");
    end
  endtask

  // Start an op then assert reset after n_neg negedges; no write must occur
  task automatic abort_op(input logic [4:0] d, input int n_neg, input bit in_wb);
    int n = 0;
    while (o_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    op = 3'd1; rd = d; rs1 = 5'd1; rs2 = 5'd2; imm = 8'h00; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (n_neg) @(negedge clk);
    if (in_wb) chk("pre_abort_reg2", {27'd0, o_reg2}, {27'd0, d});
    rst_n = 1'b0;
    #1;
    chk("abort_reg2",   {27'd0, o_reg2},   32'd0);
    chk("abort_done",   {31'd0, o_done},   32'd0);
    chk("abort_ready",  {31'd0, o_ready},  32'd1);
    chk("abort_result", {24'd0, o_result}, 32'd0);
    last_res = 8'h00;
    last_z   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t, ta, tb;
    for (int i = 0; i < 32; i++) mrf[i] = 8'h00;

    // Reset and idle behaviour
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  {31'd0, o_ready},  32'd1);
    chk("rst_reg2",   {27'd0, o_reg2},   32'd0);
    chk("rst_data2",  {24'd0, o_data2},  32'd0);
    chk("rst_done",   {31'd0, o_done},   32'd0);
    chk("rst_result", {24'd0, o_result}, 32'd0);
    chk("rst_zero",   {31'd0, o_zero},   32'd0);
    rst_n  = 1'b1;
    rf_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, o_ready}, 32'd1);
      chk("idle_reg2",  {27'd0, o_reg2},  32'd0);
      chk("idle_done",  {31'd0, o_done},  32'd0);
    end

    // Directed op sequence
    send(3'd7, 5'd1, 5'd0, 5'd0, 8'h37, 1'b0, t); finish_op(t);
    send(3'd7, 5'd2, 5'd0, 5'd0, 8'hAA, 1'b0, t); finish_op(t);
    send(3'd1, 5'd3, 5'd1, 5'd2, 8'h00, 1'b0, t); finish_op(t);
    send(3'd2, 5'd4, 5'd1, 5'd2, 8'h00, 1'b0, t); finish_op(t);
    send(3'd5, 5'd5, 5'd1, 5'd1, 8'h00, 1'b0, t); finish_op(t);
    chk("xor_zero_flag", {31'd0, o_zero}, 32'd1);
    send(3'd7, 5'd0, 5'd0, 5'd0, 8'hFF, 1'b0, t); finish_op(t);
    send(3'd6, 5'd6, 5'd0, 5'd0, 8'h00, 1'b0, t); finish_op(t);
    send(3'd0, 5'd9, 5'd1, 5'd2, 8'h44, 1'b0, t); finish_op(t);
    chk("nop_result", {24'd0, o_result}, 32'd0);
    send(3'd3, 5'd8, 5'd1, 5'd2, 8'h00, 1'b0, t); finish_op(t);
    send(3'd4, 5'd11, 5'd1, 5'd2, 8'h00, 1'b0, t); finish_op(t);

    // valid held high with changing fields while busy
    send(3'd7, 5'd12, 5'd0, 5'd0, 8'h5A, 1'b1, ta);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      op = 3'd7; rd = 5'd10; imm = 8'h11 + 8'(i);
    end
    finish_op(ta);
    op = 3'd2; rd = 5'd13; rs1 = 5'd12; rs2 = 5'd1; imm = 8'h00;
    push_exp(3'd2, 5'd13, 5'd12, 5'd1, 8'h00);
    @(negedge clk);
    chk("held_ready_idle", {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    tb = cyc;
    valid = 1'b0;
    chk("held_accept_slot", tb - ta, LAT + 2);
    finish_op(tb);

    // Reset during EXEC (READ in fast mode) and during WB
    abort_op(5'd7, LAT, 1'b0);
    abort_op(5'd14, LAT + 1, 1'b1);

    // ADD after reset: write lands LAT+1 edges after accept
    send(3'd1, 5'd15, 5'd1, 5'd2, 8'h00, 1'b0, t); finish_op(t);
    @(posedge clk);
    #1;

    // Register file contents against hand-computed values
    chk("rf_r0",  {24'd0, rf[0]},  32'h00);
    chk("rf_r1",  {24'd0, rf[1]},  32'h37);
    chk("rf_r2",  {24'd0, rf[2]},  32'hAA);
    chk("rf_r3",  {24'd0, rf[3]},  32'hE1);
    chk("rf_r4",  {24'd0, rf[4]},  32'h8D);
    chk("rf_r5",  {24'd0, rf[5]},  32'h00);
    chk("rf_r6",  {24'd0, rf[6]},  32'h00);
    chk("rf_r7",  {24'd0, rf[7]},  32'h00);
    chk("rf_r8",  {24'd0, rf[8]},  32'h22);
    chk("rf_r9",  {24'd0, rf[9]},  32'h00);
    chk("rf_r10", {24'd0, rf[10]}, 32'h00);
    chk("rf_r11", {24'd0, rf[11]}, 32'hBF);
    chk("rf_r12", {24'd0, rf[12]}, 32'h5A);
    chk("rf_r13", {24'd0, rf[13]}, 32'h23);
    chk("rf_r14", {24'd0, rf[14]}, 32'h00);
    chk("rf_r15", {24'd0, rf[15]}, 32'hE1);
    chk("sb_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
